mux_4to1_rr_arbiter: RTL and testbench
======================================

// Module: mux_4to1_rr_arbiter
// PURPOSE
//   Shares one 4:1 datapath mux between four valid/ready requesters. Round-robin
//   arbitration; the grant is held for a whole burst, terminated by req_last.
//   Drives sel[1:0] of the shared mux.
//   Sits between four producer channels and a single downstream consumer.
// PARAMETERS
//   WIDTH      4   data width per requester channel
//   MAX_BURST  8   beat limit per grant; used only with MUX_ARB_BURST_LIMIT_EN, range 1..255
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous reset, active-low
//   req_valid  in   4          per-requester data valid
//   req_data   in   4*WIDTH    requester i occupies [i*WIDTH +: WIDTH]
//   req_last   in   4          final beat of the requester's burst
//   req_ready  out  4          per-requester accept
//   out_valid  out  1          downstream valid
//   out_data   out  WIDTH      selected requester data
//   out_last   out  1          selected requester last
//   out_ready  in   1          downstream accept
//   sel        out  2          mux select; index of the granted requester
//   grant      out  4          one-hot grant; 0 when idle
//   burst_cut  out  1          1-cycle pulse when a burst is force-terminated
// BEHAVIOUR
//   - Reset values, applied asynchronously on rst_n=0:
//     - state=IDLE, ptr=0, sel=0, grant=0, beat_cnt=0, burst_cut=0.
//     - out_valid=0 and req_ready=0 follow from grant=0.
//   - FSM states:
//     - IDLE: if any req_valid, the next clock grants the first requester found
//       searching ptr, ptr+1, ... mod 4. state->GRANT; sel and grant are registered.
//     - GRANT: out_valid=req_valid[sel]; out_data=req_data[sel]; out_last=req_last[sel].
//       These are combinational through the mux.
//     - req_ready[i]=out_ready & grant[i]. All non-granted ready bits are 0.
//   - Transfer: out_valid & out_ready in the same cycle.
//     - Transfer with out_last: next state IDLE, ptr<=sel+1 (wraps 3->0), grant<=0.
//   - Latency: a request arriving in IDLE reaches out_valid 1 cycle later.
//     - Every burst costs 1 idle arbitration cycle; there are no back-to-back grants.
//   - Granted requester drops valid mid-burst: the grant is held and out_valid=0 (bubble).
//     Other requesters wait.
//   - Changes to req_valid of non-granted channels are ignored during GRANT.
//   - A single-beat burst (req_last=1 on the first beat) is legal.
//   - A request with all four channels valid, ptr=2, grants ch2, then ch3, ch0, ch1.
//   - rst_n low mid-burst: immediate abandon. No partial-burst state survives.
//   - sel holds its last value while IDLE and is only meaningful when grant!=0.
// CONFIGURATION
//   MUX_ARB_BURST_LIMIT_EN defined:
//     - beat_cnt (8 bit) increments on each transfer and clears on entering IDLE.
//     - When a transfer makes beat_cnt==MAX_BURST without out_last: state->IDLE,
//       ptr<=sel+1, and burst_cut pulses 1 cycle in the following cycle.
//     - The remainder of the cut burst re-arbitrates as a new burst.
//   MUX_ARB_BURST_LIMIT_EN undefined:
//     - No counter is built. Bursts end only on req_last. burst_cut is tied 0.
// TESTING
//   1. rst_n=0, random inputs -> grant=0, out_valid=0, req_ready=0, burst_cut=0.
//   2. Only ch1 valid, 3 beats 0x1,0x2,0x3 with last on beat 3, out_ready=1:
//      -> sel=1 from cycle 1; out_data 1,2,3; return to IDLE.
//   3. All valid, single-beat bursts, out_ready=1 -> grant order 0,1,2,3,0.
//      out_valid pattern 0,1,0,1,...
//   4. ch2 burst with out_ready=0 for 2 cycles mid-burst -> data held stable.
//      req_ready[2]=0 during the stall; no beat lost or duplicated.
//   5. rst_n pulsed low during ch3 beat 2 -> outputs return to reset values that cycle.
//      After release, arbitration restarts from ptr=0.
//   6. With MUX_ARB_BURST_LIMIT_EN, MAX_BURST=4, ch0 sends 6 beats and ch1 is valid:
//      -> cut after beat 4, burst_cut=1, ch1 is granted next, ch0 resumes afterwards.

Source files
------------

// File: rtl/mux_4to1_rr_arbiter.sv
// rtl/mux_4to1_rr_arbiter.sv - round-robin burst arbiter driving a shared 4:1 valid/ready mux
// Optional beat limit per grant: define MUX_ARB_BURST_LIMIT_EN.
module mux_4to1_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  input  logic [3:0]         req_last,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [1:0]         sel,
  output logic [3:0]         grant,
  output logic               burst_cut
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       any_valid;
  logic       xfer;
  logic       cut_now;
  logic       end_burst;

  // Scan from the highest offset down so the requester nearest ptr wins.
  always_comb begin
    any_valid = |req_valid;
    pick      = ptr;
    idx       = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_valid[idx]) pick = idx;
    end
  end

  assign out_valid = (|grant) & req_valid[sel];
  assign out_data  = req_data[int'(sel)*WIDTH +: WIDTH];
  assign out_last  = (|grant) & req_last[sel];
  assign req_ready = {4{out_ready}} & grant;
  assign xfer      = out_valid & out_ready;
  assign end_burst = xfer & (out_last | cut_now);

`ifdef MUX_ARB_BURST_LIMIT_EN
  logic [7:0] beat_cnt;

  assign cut_now = ~out_last & ((beat_cnt + 8'd1) == 8'(MAX_BURST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= 8'd0;
      burst_cut <= 1'b0;
    end else begin
      burst_cut <= xfer & cut_now;
      if (end_burst) beat_cnt <= 8'd0;
      else if (xfer) beat_cnt <= beat_cnt + 8'd1;
    end
  end
`else
  assign cut_now   = 1'b0;
  assign burst_cut = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      grant <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            sel   <= pick;
            grant <= 4'b0001 << pick;
            state <= ST_GRANT;
          end
        end
        default: begin
          if (end_burst) begin
            state <= ST_IDLE;
            ptr   <= sel + 2'd1;
            grant <= 4'b0000;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// tb/tb_mux_4to1_rr_arbiter.sv - self-checking bench for mux_4to1_rr_arbiter
// Burst-limit scenario runs only when MUX_ARB_BURST_LIMIT_EN is defined.
module tb_mux_4to1_rr_arbiter;

  localparam int W  = 4;
  localparam int MB = 4;
`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_last;
  logic [3:0]     req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [1:0]     sel;
  logic [3:0]     grant;
  logic           burst_cut;

  mux_4to1_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .grant(grant), .burst_cut(burst_cut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t        q[4][$];
  int           log_ch[$];
  logic [W-1:0] log_d[$];
  logic [3:0]   en;
  int           checks = 0;
  int           failures = 0;
  // Reference: granted channel (-1 = idle), rotation pointer, beats this grant, pending cut pulse
  int           m_cur, m_ptr, m_beats;
  bit           m_cut;
  int           cut_seen;
  logic [W-1:0] seen_data;
  logic         seen_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_ptr = 0; m_beats = 0; m_cut = 1'b0;
    for (int i = 0; i < 4; i++) q[i].delete();
    log_ch.delete(); log_d.delete();
    cut_seen = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0 && en[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*W +: W]    = q[i][0].d;
        req_last[i]           = q[i][0].l;
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*W +: W]    = W'($urandom);
        req_last[i]           = 1'($urandom);
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] eg, er;
    logic       ev;
    eg = 4'b0; er = 4'b0; ev = 1'b0;
    if (m_cur >= 0) begin
      eg = 4'b0001 << m_cur;
      ev = req_valid[m_cur];
      er = out_ready ? eg : 4'b0;
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("burst_cut", 32'(burst_cut), 32'(m_cut));
    if (m_cur >= 0) begin
      chk("sel", 32'(sel), 32'(m_cur));
      chk("out_data", 32'(out_data), 32'(req_data[m_cur*W +: W]));
      chk("out_last", 32'(out_last), 32'(req_last[m_cur]));
    end
    cut_seen   += int'(burst_cut);
    seen_data  = out_data;
    seen_valid = out_valid;
  endtask

  task automatic model_update();
    bit cut_n;
    cut_n = 1'b0;
    if (m_cur < 0) begin
      for (int k = 3; k >= 0; k--)
        if (req_valid[(m_ptr + k) % 4]) m_cur = (m_ptr + k) % 4;
      m_beats = 0;
    end else if (req_valid[m_cur] && out_ready) begin
      log_ch.push_back(m_cur);
      log_d.push_back(req_data[m_cur*W +: W]);
      void'(q[m_cur].pop_front());
      m_beats++;
      if (req_last[m_cur] || (LIMIT && m_beats == MB)) begin
        cut_n   = !req_last[m_cur];
        m_ptr   = (m_cur + 1) % 4;
        m_cur   = -1;
        m_beats = 0;
      end
    end
    m_cut = cut_n;
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0; en = 4'hf;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_burst(input int ch, input int n, input int base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = W'(base + i);
      b.l = (i == n - 1);
      q[ch].push_back(b);
    end
  endtask

  task automatic run_until_empty(input int budget, input bit rnd);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_cur >= 0) && n < budget) begin
      en        = rnd ? 4'($urandom) | 4'b0001 << $urandom_range(0, 3) : 4'hf;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic check_log(input string tag, input int ec[$], input logic [W-1:0] ed[$]);
    chk({tag, "_len"}, 32'(log_ch.size()), 32'(ec.size()));
    for (int i = 0; i < ec.size() && i < log_ch.size(); i++) begin
      chk({tag, "_ch"}, 32'(log_ch[i]), 32'(ec[i]));
      chk({tag, "_data"}, 32'(log_d[i]), 32'(ed[i]));
    end
  endtask

  initial begin
    int           ec[$];
    logic [W-1:0] ed[$];
    int           vpat[$];
    logic [W-1:0] held;

    // Reset with random inputs
    do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'($urandom); req_data = 16'($urandom); req_last = 4'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_burst_cut", 32'(burst_cut), 32'd0);
    end
    do_reset();

    // Only ch1, three beats 1,2,3
    push_burst(1, 3, 1);
    out_ready = 1'b1;
    tick();
    chk("t2_sel", 32'(sel), 32'd1);
    run_until_empty(20, 1'b0);
    ec = '{1, 1, 1}; ed = '{4'h1, 4'h2, 4'h3};
    check_log("t2", ec, ed);
    tick();

    // All valid, single-beat bursts
    do_reset();
    push_burst(0, 1, 8); push_burst(1, 1, 9); push_burst(2, 1, 10);
    push_burst(3, 1, 11); push_burst(0, 1, 12);
    vpat.delete();
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      tick();
      vpat.push_back(int'(seen_valid));
    end
    for (int i = 0; i < 10; i++) chk("t3_valid_pattern", 32'(vpat[i]), 32'(i % 2));
    ec = '{0, 1, 2, 3, 0}; ed = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
    check_log("t3", ec, ed);

    // ch2 burst stalled for two cycles
    log_ch.delete(); log_d.delete();
    push_burst(2, 4, 5);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    tick();
    held = seen_data;
    tick();
    chk("t4_held_data", 32'(seen_data), 32'(held));
    chk("t4_held_data_val", 32'(held), 32'h6);
    chk("t4_stall_ready", 32'(req_ready[2]), 32'd0);
    run_until_empty(20, 1'b0);
    ec = '{2, 2, 2, 2}; ed = '{4'h5, 4'h6, 4'h7, 4'h8};
    check_log("t4", ec, ed);

    // Reset pulsed during ch3 beat 2
    push_burst(3, 4, 1);
    out_ready = 1'b1;
    tick(); tick();
    drive_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    chk("t5_burst_cut", 32'(burst_cut), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_burst(2, 1, 3); push_burst(3, 1, 4);
    run_until_empty(20, 1'b0);
    ec = '{2, 3}; ed = '{4'h3, 4'h4};
    check_log("t5", ec, ed);

`ifdef MUX_ARB_BURST_LIMIT_EN
    // Burst limit: ch0 six beats, ch1 waiting
    do_reset();
    push_burst(0, 6, 1); push_burst(1, 1, 10);
    run_until_empty(40, 1'b0);
    tick();
    ec = '{0, 0, 0, 0, 1, 0, 0}; ed = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'h5, 4'h6};
    check_log("t6", ec, ed);
    chk("t6_cut_count", 32'(cut_seen), 32'd1);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 2) != 0) push_burst(i, $urandom_range(1, 10), int'($urandom_range(0, 15)));
      run_until_empty(400, 1'b1);
    end
    if (!LIMIT) chk("no_cut_without_limit", 32'(cut_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
